// File: rtl/rv32_mc_core.sv
// Multi-cycle RV32I-subset core, one shared synchronous memory port.
// Define RV_MUL_EN to add R-type mul; otherwise that encoding is invalid.
module rv32_mc_core #(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] IMEM_TOP  = 32'd4095,
  parameter logic [31:0] DMEM_BASE = 32'd4096,
  parameter logic [31:0] DMEM_TOP  = 32'd8191
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic [2:0]      o_status,
  output logic            o_status_valid,
  output logic            o_we,
  output logic [XLEN-1:0] o_addr,
  output logic [XLEN-1:0] o_wdata,
  input  logic [XLEN-1:0] i_rdata
);

  typedef enum logic [2:0] {
    S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
  } state_e;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_EOF = 7'b1110011;

  localparam logic [2:0] ST_R   = 3'd0;
  localparam logic [2:0] ST_I   = 3'd1;
  localparam logic [2:0] ST_S   = 3'd2;
  localparam logic [2:0] ST_B   = 3'd3;
  localparam logic [2:0] ST_INV = 3'd4;
  localparam logic [2:0] ST_EOF = 3'd5;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, ir_q, a_q, b_q;
  logic [XLEN-1:0] res_q, npc_q, ea_q;
  logic [2:0]      st_q;
  logic            wr_q, wait_q;
  logic [XLEN-1:0] rf_q [32];

  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i, imm_s, imm_b;
  logic [XLEN-1:0] sum, dif, addi_s, ea;
  logic [XLEN-1:0] res_d, npc_d;
  logic [2:0]      st_d;
  logic            wr_d, ovf, is_mem, is_ld, is_st, take;

  assign opc   = ir_q[6:0];
  assign rd    = ir_q[11:7];
  assign f3    = ir_q[14:12];
  assign f7    = ir_q[31:25];
  assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7],
                  ir_q[30:25], ir_q[11:8], 1'b0};

  assign sum    = a_q + b_q;
  assign dif    = a_q - b_q;
  assign addi_s = a_q + imm_i;
  assign is_ld  = (opc == OP_LD);
  assign is_st  = (opc == OP_ST);
  assign ea     = a_q + (is_st ? imm_s : imm_i);

  always_comb begin
    res_d  = '0;
    npc_d  = pc_q + 32'd4;
    st_d   = ST_INV;
    wr_d   = 1'b0;
    ovf    = 1'b0;
    is_mem = 1'b0;
    take   = 1'b0;
    case (opc)
      OP_R: begin
        st_d = ST_R;
        wr_d = 1'b1;
        case ({f7, f3})
          {7'h00, 3'd0}: begin
            res_d = sum;
            ovf   = (a_q[31] == b_q[31]) && (sum[31] != a_q[31]);
          end
          {7'h20, 3'd0}: begin
            res_d = dif;
            ovf   = (a_q[31] != b_q[31]) && (dif[31] != a_q[31]);
          end
          {7'h00, 3'd1}: res_d = a_q << b_q[4:0];
          {7'h00, 3'd2}: res_d = {{(XLEN-1){1'b0}},
                                  $signed(a_q) < $signed(b_q)};
          {7'h00, 3'd5}: res_d = a_q >> b_q[4:0];
          {7'h00, 3'd6}: res_d = a_q | b_q;
          {7'h00, 3'd7}: res_d = a_q & b_q;
`ifdef RV_MUL_EN
          {7'h01, 3'd0}: res_d = a_q * b_q;
`endif
          default: begin
            st_d = ST_INV;
            wr_d = 1'b0;
          end
        endcase
      end
      OP_IMM: if (f3 == 3'd0) begin
        st_d  = ST_I;
        wr_d  = 1'b1;
        res_d = addi_s;
        ovf   = (a_q[31] == imm_i[31]) && (addi_s[31] != a_q[31]);
      end
      OP_LD: if (f3 == 3'd2) begin
        st_d   = ST_I;
        wr_d   = 1'b1;
        is_mem = 1'b1;
      end
      OP_ST: if (f3 == 3'd2) begin
        st_d   = ST_S;
        is_mem = 1'b1;
      end
      OP_BR: begin
        st_d = ST_B;
        unique case (f3)
          3'd0:    take = (a_q == b_q);
          3'd1:    take = (a_q != b_q);
          3'd4:    take = ($signed(a_q) < $signed(b_q));
          3'd5:    take = ($signed(a_q) >= $signed(b_q));
          default: st_d = ST_INV;
        endcase
        if (take) npc_d = pc_q + imm_b;
      end
      OP_EOF: st_d = ST_EOF;
      default: st_d = ST_INV;
    endcase
    // Late faults override the instruction's own status code.
    if (st_d < ST_INV) begin
      if (ovf || npc_d > IMEM_TOP ||
          (is_mem && (ea < DMEM_BASE || ea > DMEM_TOP))) begin
        st_d = ST_INV;
      end
    end
    if (st_d >= ST_INV) wr_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= S_IF;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:  state_d = S_ID;
      S_ID:  state_d = S_EX;
      S_EX:  state_d = (st_d < ST_INV && is_mem) ? S_MEM : S_WB;
      S_MEM: state_d = (is_ld && !wait_q) ? S_MEM : S_WB;
      S_WB:  state_d = (st_q >= ST_INV) ? S_HALT : S_IF;
      default: state_d = S_HALT;
    endcase
  end

  always_comb begin
    o_we           = 1'b0;
    o_addr         = '0;
    o_wdata        = '0;
    o_status_valid = (state_q == S_WB);
    o_status       = st_q;
    case (state_q)
      S_IF:  o_addr = pc_q;
      S_MEM: begin
        o_addr  = ea_q;
        o_we    = is_st;
        o_wdata = is_st ? b_q : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pc_q   <= '0;
      ir_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      npc_q  <= '0;
      ea_q   <= '0;
      st_q   <= '0;
      wr_q   <= 1'b0;
      wait_q <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      case (state_q)
        S_ID: begin
          ir_q <= i_rdata;
          a_q  <= rf_q[i_rdata[19:15]];
          b_q  <= rf_q[i_rdata[24:20]];
        end
        S_EX: begin
          res_q  <= res_d;
          npc_q  <= npc_d;
          st_q   <= st_d;
          ea_q   <= ea;
          wr_q   <= wr_d;
          wait_q <= 1'b0;
        end
        S_MEM: begin
          wait_q <= 1'b1;
          if (wait_q) res_q <= i_rdata;
        end
        S_WB: begin
          if (wr_q && rd != 5'd0) rf_q[rd] <= res_q;
          if (st_q < ST_INV) pc_q <= npc_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_mc_core.sv
// Directed-vector bench for rv32_mc_core with a 2048-word memory model.
module tb_rv32_mc_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  status;
  logic        sv, we;
  logic [31:0] addr, wdata, rdata;

  always #5 clk = ~clk;

  rv32_mc_core dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_status(status), .o_status_valid(sv),
    .o_we(we), .o_addr(addr), .o_wdata(wdata),
    .i_rdata(rdata)
  );

  logic [31:0] mem [0:2047];
  always @(posedge clk) begin
    rdata <= mem[addr[12:2]];
    if (we) mem[addr[12:2]] = wdata;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  logic [2:0]  sq [$];
  int          stq [$];
  logic [31:0] wa [$];
  logic [31:0] wd [$];
  int          clash = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (sv) begin
        sq.push_back(status);
        stq.push_back(cyc);
      end
      if (we) begin
        wa.push_back(addr);
        wd.push_back(wdata);
      end
      if (sv && we) clash++;
    end
  end

  int nvec = 0;
  int nerr = 0;
  logic [31:0] prog [$];
  logic [31:0] dpre = 32'h0;
  localparam logic [31:0] EOF = 32'h0000_0073;

  function automatic logic [31:0] f_i(int imm, int rs1, int f3,
                                      int rd, logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] ADDI(int rd, int rs1, int imm);
    return f_i(imm, rs1, 0, rd, 7'b0010011);
  endfunction
  function automatic logic [31:0] LW(int rd, int rs1, int imm);
    return f_i(imm, rs1, 2, rd, 7'b0000011);
  endfunction
  function automatic logic [31:0] SW(int rs2, int rs1, int imm);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010,
            imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] RR(int f7, int rs2, int rs1,
                                     int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0],
            rd[4:0], 7'b0110011};
  endfunction
  function automatic logic [31:0] BR(int f3, int rs1, int rs2, int imm);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0],
            imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic boot();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    foreach (prog[i]) mem[i] = prog[i];
    mem[1026] = dpre;
    sq.delete(); stq.delete(); wa.delete(); wd.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(int n);
    boot();
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    nvec++;
    if ({we, sv, status, addr, wdata} !== 69'd0) begin
      nerr++;
      $display("FAIL reset_outputs got we=%b sv=%b st=%0d a=%h d=%h exp 0",
               we, sv, status, addr, wdata);
    end
  endtask

  task automatic test_addi_eof();
    prog = {ADDI(1, 0, 5), EOF};
    run(30);
    nvec++;
    if (sq.size() !== 2) begin
      nerr++; $display("FAIL ae_count got %0d exp 2", sq.size());
    end
    nvec++;
    if (sq[0] !== 3'd1 || stq[0] !== 3) begin
      nerr++; $display("FAIL ae_first got st=%0d t=%0d exp 1 @3", sq[0], stq[0]);
    end
    nvec++;
    if (sq[1] !== 3'd5 || stq[1] !== 7) begin
      nerr++; $display("FAIL ae_eof got st=%0d t=%0d exp 5 @7", sq[1], stq[1]);
    end
    nvec++;
    if (dut.rf_q[1] !== 32'd5) begin
      nerr++; $display("FAIL ae_x1 got %h exp 5", dut.rf_q[1]);
    end
  endtask

  task automatic test_overflow();
    prog = {ADDI(1, 0, -1), ADDI(2, 0, 1), RR(0, 2, 1, 5, 1),
            RR(0, 1, 1, 0, 2), EOF};
    run(40);
    nvec++;
    if (sq.size() !== 4 || sq[2] !== 3'd0 || sq[3] !== 3'd4) begin
      nerr++;
      $display("FAIL ovf_status got n=%0d s2=%0d s3=%0d exp 4,0,4",
               sq.size(), sq[2], sq[3]);
    end
    nvec++;
    if (dut.rf_q[1] !== 32'h7FFF_FFFF || dut.rf_q[2] !== 32'd1) begin
      nerr++;
      $display("FAIL ovf_regs got x1=%h x2=%h exp 7fffffff 1",
               dut.rf_q[1], dut.rf_q[2]);
    end
  endtask

  task automatic test_sw_lw();
    dpre = 32'hCAFE_F00D;
    prog = {ADDI(3, 0, 1), ADDI(6, 0, 2047), ADDI(6, 6, 2047),
            ADDI(6, 6, 2), SW(3, 6, 0), LW(4, 6, 0), SW(4, 6, 4),
            LW(7, 6, 8), EOF};
    run(70);
    dpre = 32'h0;
    nvec++;
    if (sq.size() !== 9 || sq[8] !== 3'd5) begin
      nerr++; $display("FAIL mem_count got %0d exp 9", sq.size());
    end
    nvec++;
    if (sq[4] !== 3'd2 || stq[4] !== 20) begin
      nerr++; $display("FAIL sw_status got st=%0d t=%0d exp 2 @20", sq[4], stq[4]);
    end
    nvec++;
    if (sq[5] !== 3'd1 || stq[5] !== 26) begin
      nerr++; $display("FAIL lw_status got st=%0d t=%0d exp 1 @26", sq[5], stq[5]);
    end
    nvec++;
    if (wa.size() !== 2 || wa[0] !== 32'd4096 || wd[0] !== 32'd1 ||
        wa[1] !== 32'd4100 || wd[1] !== 32'd1) begin
      nerr++;
      $display("FAIL sw_writes got n=%0d a0=%h d0=%h a1=%h exp 1000/1 1004",
               wa.size(), wa[0], wd[0], wa[1]);
    end
    nvec++;
    if (mem[1024] !== 32'd1 || mem[1025] !== 32'd1) begin
      nerr++;
      $display("FAIL mem_words got %h %h exp 1 1", mem[1024], mem[1025]);
    end
    nvec++;
    if (dut.rf_q[4] !== 32'd1 || dut.rf_q[7] !== 32'hCAFE_F00D) begin
      nerr++;
      $display("FAIL lw_regs got x4=%h x7=%h exp 1 cafef00d",
               dut.rf_q[4], dut.rf_q[7]);
    end
  endtask

  task automatic test_branch();
    prog = {ADDI(1, 0, 7), ADDI(2, 0, 7), BR(0, 1, 2, 8), ADDI(5, 0, 9),
            BR(1, 1, 2, 8), ADDI(6, 0, 3), ADDI(7, 0, -1),
            BR(4, 7, 1, 8), ADDI(8, 0, 1), EOF};
    run(50);
    nvec++;
    if (sq.size() !== 8 || stq[7] !== 31 || sq[7] !== 3'd5) begin
      nerr++;
      $display("FAIL br_count got n=%0d tlast=%0d exp 8 @31", sq.size(), stq[7]);
    end
    nvec++;
    if (sq[2] !== 3'd3 || sq[3] !== 3'd3 || sq[4] !== 3'd1 ||
        sq[6] !== 3'd3) begin
      nerr++;
      $display("FAIL br_status got %0d %0d %0d %0d exp 3 3 1 3",
               sq[2], sq[3], sq[4], sq[6]);
    end
    nvec++;
    if (dut.rf_q[5] !== 32'd0 || dut.rf_q[6] !== 32'd3 ||
        dut.rf_q[8] !== 32'd0) begin
      nerr++;
      $display("FAIL br_regs got x5=%h x6=%h x8=%h exp 0 3 0",
               dut.rf_q[5], dut.rf_q[6], dut.rf_q[8]);
    end
  endtask

  task automatic test_invalid();
    prog = {LW(5, 0, 0), EOF};
    run(30);
    nvec++;
    if (sq.size() !== 1 || sq[0] !== 3'd4 || stq[0] !== 3 ||
        wa.size() !== 0) begin
      nerr++;
      $display("FAIL bad_lw got n=%0d st=%0d t=%0d wr=%0d exp 1 4 @3 0",
               sq.size(), sq[0], stq[0], wa.size());
    end
    prog = {ADDI(1, 0, 1), BR(0, 0, 0, -8), EOF};
    run(30);
    nvec++;
    if (sq.size() !== 2 || sq[1] !== 3'd4 || dut.rf_q[1] !== 32'd1) begin
      nerr++;
      $display("FAIL bad_pc got n=%0d st=%0d x1=%h exp 2 4 1",
               sq.size(), sq[1], dut.rf_q[1]);
    end
    prog = {32'hFFFF_FFFF, EOF};
    run(30);
    nvec++;
    if (sq.size() !== 1 || sq[0] !== 3'd4) begin
      nerr++;
      $display("FAIL bad_op got n=%0d st=%0d exp 1 4", sq.size(), sq[0]);
    end
  endtask

  task automatic test_mul();
    prog = {ADDI(1, 0, 3), ADDI(2, 0, -2), RR(1, 2, 1, 0, 3), EOF};
    run(30);
`ifdef RV_MUL_EN
    nvec++;
    if (sq.size() !== 4 || sq[2] !== 3'd0 ||
        dut.rf_q[3] !== 32'hFFFF_FFFA) begin
      nerr++;
      $display("FAIL mul got n=%0d st=%0d x3=%h exp 4 0 fffffffa",
               sq.size(), sq[2], dut.rf_q[3]);
    end
`else
    nvec++;
    if (sq.size() !== 3 || sq[2] !== 3'd4 || dut.rf_q[3] !== 32'd0) begin
      nerr++;
      $display("FAIL mul_off got n=%0d st=%0d x3=%h exp 3 4 0",
               sq.size(), sq[2], dut.rf_q[3]);
    end
`endif
  endtask

  task automatic test_reset_mid();
    bit seen;
    prog = {ADDI(3, 0, 1), ADDI(6, 0, 2047), ADDI(6, 6, 2047),
            ADDI(6, 6, 2), SW(3, 6, 0), EOF};
    boot();
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (we) seen = 1'b1;
    end
    nvec++;
    if (!seen) begin
      nerr++; $display("FAIL rm_we_seen got 0 exp 1 within 40 cycles");
    end
    rst_n = 1'b0;
    @(negedge clk);
    nvec++;
    if (we !== 1'b0 || sv !== 1'b0 || addr !== 32'd0) begin
      nerr++;
      $display("FAIL rm_outputs got we=%b sv=%b a=%h exp 0 0 0", we, sv, addr);
    end
    nvec++;
    if (dut.rf_q[3] !== 32'd0 || dut.rf_q[6] !== 32'd0) begin
      nerr++;
      $display("FAIL rm_regs got x3=%h x6=%h exp 0 0",
               dut.rf_q[3], dut.rf_q[6]);
    end
    sq.delete(); stq.delete(); wa.delete(); wd.delete();
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    nvec++;
    if (sq.size() !== 6 || sq[0] !== 3'd1 || stq[0] !== 3 ||
        sq[4] !== 3'd2 || sq[5] !== 3'd5) begin
      nerr++;
      $display("FAIL rm_restart got n=%0d s0=%0d t0=%0d exp 6 1 @3",
               sq.size(), sq[0], stq[0]);
    end
  endtask

  initial begin
    test_reset();
    test_addi_eof();
    test_overflow();
    test_sw_lw();
    test_branch();
    test_invalid();
    test_mul();
    test_reset_mid();
    nvec++;
    if (clash !== 0) begin
      nerr++; $display("FAIL we_sv_overlap got %0d exp 0", clash);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
